// File: rtl/vnu_sched.sv
// rtl/vnu_sched.sv - variable-node update sequencer with a shared vnu datapath
// Three-stage read / compute / write pipeline over N columns, tracking hard-decision flips.

module vnu #(
  parameter int data_w = 8,
  parameter int D      = 12,
  parameter int ext_w  = 3
) (
  input  logic signed [data_w-1:0]   l,
  input  logic        [data_w*D-1:0] r,
  output logic        [data_w*D-1:0] q,
  output logic                       dec
);
  localparam int sum_w  = data_w + ext_w;
  // Never narrower than D+1 full-scale terms need, so the total cannot wrap.
  localparam int need_w = data_w + $clog2(D + 1);
  localparam int acc_w  = (sum_w > need_w) ? sum_w : need_w;
  localparam logic signed [acc_w-1:0] q_max = acc_w'((2 ** (data_w - 1)) - 1);
  localparam logic signed [acc_w-1:0] q_min = -q_max;

  logic signed [acc_w-1:0]  total;
  logic signed [acc_w-1:0]  diff;
  logic signed [data_w-1:0] lane;

  always_comb begin
    total = acc_w'(l);
    diff  = '0;
    lane  = '0;
    q     = '0;
    for (int i = 0; i < D; i++) begin
      lane  = r[i*data_w +: data_w];
      total = total + acc_w'(lane);
    end
    for (int i = 0; i < D; i++) begin
      lane = r[i*data_w +: data_w];
      diff = total - acc_w'(lane);
      if (diff > q_max)      diff = q_max;
      else if (diff < q_min) diff = q_min;
      q[i*data_w +: data_w] = diff[data_w-1:0];
    end
    dec = total[acc_w-1];
  end
endmodule

module vnu_sched #(
  parameter int data_w = 8,
  parameter int D      = 12,
  parameter int ext_w  = 3,
  parameter int N      = 64,
  parameter int AW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [data_w-1:0]   l_in,
  input  logic [data_w*D-1:0] r_in,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [data_w*D-1:0] wr_q,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        dec_vec,
  output logic [AW:0]         flips
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                state, state_nx;
  logic                  b_valid, c_valid, c_dec;
  logic [AW-1:0]         b_addr;
  logic [data_w*D-1:0]   q;
  logic                  dec;

  vnu #(.data_w(data_w), .D(D), .ext_w(ext_w)) u_vnu (
    .l   (l_in),
    .r   (r_in),
    .q   (q),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wr_en    = c_valid && !stall;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy  = 1'b1;
        rd_en = !stall;
        if (!stall && rd_addr == AW'(N - 1)) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (wr_en && wr_addr == AW'(N - 1)) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A stalled cycle freezes every stage; the memory holds its output meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      b_valid <= 1'b0;
      b_addr  <= '0;
      c_valid <= 1'b0;
      c_dec   <= 1'b0;
      wr_addr <= '0;
      wr_q    <= '0;
      dec_vec <= '0;
      flips   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        rd_addr <= '0;
        flips   <= '0;
      end else if (rd_en && rd_addr != AW'(N - 1)) begin
        rd_addr <= rd_addr + AW'(1);
      end
      if (!stall) begin
        b_valid <= rd_en;
        b_addr  <= rd_addr;
        c_valid <= b_valid;
        if (b_valid) begin
          wr_addr <= b_addr;
          wr_q    <= q;
          c_dec   <= dec;
        end
      end
      if (wr_en) begin
        dec_vec[wr_addr] <= c_dec;
        if (dec_vec[wr_addr] != c_dec) flips <= flips + (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_vnu_sched.sv
// tb/tb_vnu_sched.sv - directed table-driven bench for vnu_sched
// Behavioural memories answer reads; a negedge monitor checks write order and data.

module tb_vnu_sched;
  localparam int data_w = 8;
  localparam int D      = 12;
  localparam int N      = 64;
  localparam int AW     = 6;

  logic                clk = 1'b0;
  logic                rst, start, stall;
  logic                rd_en, wr_en, busy, done;
  logic [AW-1:0]       rd_addr, wr_addr;
  logic [data_w-1:0]   l_in;
  logic [data_w*D-1:0] r_in, wr_q;
  logic [N-1:0]        dec_vec;
  logic [AW:0]         flips;

  vnu_sched #(.data_w(data_w), .D(D), .ext_w(3), .N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .l_in(l_in), .r_in(r_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_q(wr_q),
    .busy(busy), .done(done), .dec_vec(dec_vec), .flips(flips)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          l_v;
    int          r_v;
    int          r_step;
    logic [63:0] mask;
    int          neg_l;
    int          neg_r;
    int          exp_q;
    int          exp_neg;
    logic [63:0] exp_dec;
    int          exp_flips;
    bit          stall_on;
    int          exp_done;
  } vec_t;

  vec_t vt[9];

  logic [data_w-1:0]   llr_mem [N];
  logic [data_w*D-1:0] msg_mem [N];

  int n_chk = 0, n_pass = 0;
  int cyc, cur;
  bit mon_on = 1'b0;
  int first_rd, first_wr, rd_cnt, rd_err, wr_cnt, order_err, data_err;
  int busy_cnt, done_cnt, done_cyc;
  logic          rd_q = 1'b0;
  logic [AW-1:0] ra_q = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", nm, act, exp);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < N; k++) begin
      llr_mem[k] = vt[v].mask[k] ? data_w'(vt[v].neg_l) : data_w'(vt[v].l_v);
      for (int i = 0; i < D; i++)
        msg_mem[k][i*data_w +: data_w] = vt[v].mask[k] ? data_w'(vt[v].neg_r)
                                                       : data_w'(vt[v].r_v + i * vt[v].r_step);
    end
  endtask

  // memory with one cycle of read latency, holding its output when not read
  always @(negedge clk) begin
    rd_q = rd_en;
    ra_q = rd_addr;
  end
  always @(posedge clk) begin
    #1;
    if (rd_q) begin
      l_in = llr_mem[ra_q];
      r_in = msg_mem[ra_q];
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (int'(rd_addr) != rd_cnt) rd_err++;
        rd_cnt++;
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (int'(wr_addr) != wr_cnt) order_err++;
        for (int i = 0; i < D; i++) begin
          logic signed [data_w-1:0] b;
          int e;
          b = wr_q[i*data_w +: data_w];
          e = vt[cur].mask[wr_addr] ? vt[cur].exp_neg : vt[cur].exp_q - i * vt[cur].r_step;
          if (int'(b) != e) data_err++;
        end
        wr_cnt++;
      end
    end
  end

  task automatic run_pass(input int v);
    int stalls;
    fill(v);
    cur = v;
    first_rd = -1; first_wr = -1; rd_cnt = 0; rd_err = 0; wr_cnt = 0;
    order_err = 0; data_err = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    stalls = vt[v].stall_on ? 4 : 0;
    @(posedge clk); #1;
    cyc = 0; start = 1'b1; mon_on = 1'b1;
    while (done_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      stall = vt[v].stall_on && ((cyc >= 5 && cyc <= 7) || cyc == 40);
    end
    repeat (2) begin
      @(posedge clk); #1;
      cyc++;
      stall = 1'b0;
    end
    mon_on = 1'b0;
    chk($sformatf("done_cyc[%0d]", v), 64'(done_cyc), 64'(vt[v].exp_done));
    chk($sformatf("done_cnt[%0d]", v), 64'(done_cnt), 64'd1);
    chk($sformatf("first_rd[%0d]", v), 64'(first_rd), 64'd1);
    chk($sformatf("first_wr[%0d]", v), 64'(first_wr), 64'd3);
    chk($sformatf("rd_cnt[%0d]", v), 64'(rd_cnt), 64'(N));
    chk($sformatf("rd_err[%0d]", v), 64'(rd_err), 64'd0);
    chk($sformatf("wr_cnt[%0d]", v), 64'(wr_cnt), 64'(N));
    chk($sformatf("order_err[%0d]", v), 64'(order_err), 64'd0);
    chk($sformatf("data_err[%0d]", v), 64'(data_err), 64'd0);
    chk($sformatf("busy_cnt[%0d]", v), 64'(busy_cnt), 64'(N + 2 + stalls));
    chk($sformatf("dec_vec[%0d]", v), 64'(dec_vec), vt[v].exp_dec);
    chk($sformatf("flips[%0d]", v), 64'(flips), 64'(vt[v].exp_flips));
  endtask

  initial begin
    vt[0] = '{5, 1, 0, 64'h0, 0, 0, 16, 0, 64'h0, 0, 1'b0, 67};
    vt[1] = '{5, 1, 1, 64'h0, 0, 0, 82, 0, 64'h0, 0, 1'b0, 67};
    vt[2] = '{127, 127, 0, 64'h0, 0, 0, 127, 0, 64'h0, 0, 1'b0, 67};
    vt[3] = '{-128, -128, 0, 64'h0, 0, 0, -127, 0, {64{1'b1}}, 64, 1'b0, 67};
    vt[4] = '{-117, -1, 0, 64'h0, 0, 0, -127, 0, {64{1'b1}}, 0, 1'b0, 67};
    vt[5] = '{5, 1, 0, 64'h0, 0, 0, 16, 0, 64'h0, 64, 1'b0, 67};
    vt[6] = '{5, 1, 0, 64'h8000_0000_0000_0408, -100, -1, 16, -111, 64'h8000_0000_0000_0408, 3, 1'b0, 67};
    vt[7] = '{5, 1, 0, 64'h8000_0000_0000_0408, -100, -1, 16, -111, 64'h8000_0000_0000_0408, 0, 1'b0, 67};
    vt[8] = '{5, 1, 0, 64'h0, 0, 0, 16, 0, 64'h0, 3, 1'b1, 71};

    rst = 1'b1; start = 1'b0; stall = 1'b0;
    l_in = '0; r_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_q_lo", wr_q[63:0], 64'd0);
    chk("rst_dec_vec", 64'(dec_vec), 64'd0);
    chk("rst_flips", 64'(flips), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) run_pass(v);

    // a start mid-pass is ignored; reset mid-pass aborts and clears everything
    fill(3);
    @(posedge clk); #1;
    cyc = 0; start = 1'b1;
    while (cyc < 31) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 20);
      rst   = (cyc == 30);
      if (cyc == 21) begin
        chk("ign_busy", 64'(busy), 64'd1);
        chk("ign_rd_addr", 64'(rd_addr), 64'd20);
        chk("ign_flips", 64'(flips), 64'd18);
        chk("ign_dec_lo", 64'(dec_vec[17:0]), 64'h3ffff);
      end
    end
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_dec_vec", 64'(dec_vec), 64'd0);
    chk("abort_flips", 64'(flips), 64'd0);
    @(posedge clk); #1;
    chk("abort_wr_en2", 64'(wr_en), 64'd0);
    run_pass(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vnu_sched.md
# vnu_sched

Sequencer for the variable-node update phase of the LDPC decoder. It sweeps N variable-node columns through one shared, internally instantiated `vnu` datapath per pass: it issues read addresses to the channel-LLR and check-message memories, writes saturated variable-to-check messages back, and keeps the hard-decision vector. It also counts the hard-decision flips against the previous pass, which feeds the decoder's early-termination logic.

## Interface
- `data_w`, 8: width of the channel LLR and of each check message (two's complement).
- `D`, 12: column degree, i.e. the number of check messages per variable node.
- `ext_w`, 3: sign-extension bits used inside the `vnu` adder tree; `sum_w = data_w + ext_w`.
- `N`, 64: number of variable nodes per pass; must be at least 2.
- `AW`, clog2(N): address width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a pass; sampled only in IDLE.
- `stall`  in  1  freezes the whole pipeline for the current cycle.
- `rd_en`  out  1  read strobe to the LLR and message memories.
- `rd_addr`  out  AW  variable-node index being read.
- `l_in`  in  data_w  channel LLR; valid the cycle after the `rd_en` cycle that fetched it.
- `r_in`  in  data_w*D  check messages; same timing as `l_in`.
- `wr_en`  out  1  write strobe for the message memory.
- `wr_addr`  out  AW  variable-node index being written.
- `wr_q`  out  data_w*D  saturated variable-to-check messages.
- `busy`  out  1  high while a pass is in progress.
- `done`  out  1  one-cycle pulse when a pass completes.
- `dec_vec`  out  N  hard decisions; bit k belongs to node k.
- `flips`  out  AW+1  number of `dec_vec` bits changed in the last pass.

## Operation
- The memories have 1-cycle read latency. When `rd_en` is low they hold their output.
- **States:**
  - IDLE: `start` → RUN.
  - RUN: issues addresses 0 to N-1, one per unstalled cycle; after issuing N-1 → FLUSH.
  - FLUSH: drains the 2-stage pipeline; after the last write → DONE.
  - DONE: one cycle, asserts `done` → IDLE.
- `start` is ignored outside IDLE. `busy` is high in RUN and FLUSH.
- **Pipeline stages:**
  - Stage A: `rd_en`/`rd_addr`.
  - Stage B: memory data on `l_in`/`r_in` feeds `vnu`; the `vnu` outputs q and dec are registered together with the address.
  - Stage C: `wr_en`/`wr_addr`/`wr_q` are driven from the registers.
- **Saturation:** each sum_w-bit q is clamped symmetrically to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], which is [-127, 127] for `data_w` = 8. The value -2^(data_w-1) is never emitted.
- **Hard decision:** dec = sign of the total sum (1 = negative). In the stage-C cycle for address k, `dec_vec[k]` takes the new dec. If the new value differs from the old bit, `flips` increments.
- `flips` clears to 0 on the cycle `start` is accepted. It is stable from `done` until the next accepted `start`. `dec_vec` persists across passes.
- **Stall:** when `stall` is high, `rd_en` and `wr_en` are forced low. All state, addresses, pipeline registers, `dec_vec` and `flips` hold. Each stall cycle delays completion by one cycle. `stall` in IDLE or DONE has no effect; `done` is never stretched.
- **Reset** (also mid-pass) → IDLE. Reset values:
  - `rd_en`, `wr_en`, `busy`, `done` = 0.
  - `rd_addr`, `wr_addr`, `wr_q` = 0.
  - `dec_vec` = 0, `flips` = 0.
  - Any in-flight writes are dropped.

## Timing
- Cycle numbering: `start` is sampled high in cycle 0, and there is no stall.
- `busy` is high in cycles 1..N+2. `rd_en` is high in cycles 1..N, with `rd_addr` = c-1.
- `wr_en` is high in cycles 3..N+2, with `wr_addr` = c-3. The read-to-write latency is 2 cycles.
- `done` is high in cycle N+3. The earliest next `start` is accepted in cycle N+4.
- Throughput is 1 node per cycle. A pass takes N+3 cycles.

## Test plan
- **Basic pass:** N=64, every `l_in` = +5 and every `r_in` message = +1, no stall → per message q = 5+12-1 = 16; `wr_q` = 16 in every lane; `dec_vec` = 0; `flips` = 0; `done` in cycle 67.
- **Saturation:** `l_in` = +127 and every message = +127 → q = 127+11·127 = 1524, so `wr_q` = 127 in every lane. With all inputs -128 the lanes read -127, never -128.
- **Flip count:** first pass all positive; second pass drives a negative sum on nodes 3, 10 and 63 only → after the second pass `dec_vec` has bits 3, 10 and 63 set and `flips` = 3. A third, identical pass gives `flips` = 0.
- **Stall:** `stall` high in cycles 5-7 and in cycle 40 → 4 extra cycles, `done` in cycle 71. The write sequence is still addresses 0..63 exactly once each, in order, with correct data.
- **Ignored start and reset:** pulse `start` in cycle 20 of a pass → no effect. Assert `rst` in cycle 30 → next cycle `busy`, `wr_en` and `done` are 0 and `dec_vec` = 0. A new `start` then runs a full, correct pass.
